// File: rtl/divider_integer_pkg.sv
// Shared types and elaboration helpers for the multimode integer divider.
package divider_integer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  function automatic int unsigned num_iters(input int unsigned word_width,
                                            input int unsigned bits_per_cycle);
    return word_width / bits_per_cycle;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  function automatic bit config_ok(input int unsigned word_width,
                                   input int unsigned bits_per_cycle,
                                   input int unsigned tag_width);
    return (word_width >= 2) && (bits_per_cycle >= 1) && (tag_width >= 1) &&
           (word_width % bits_per_cycle == 0);
  endfunction

endpackage

// File: rtl/divider_integer_step.sv
// One restoring division step: shift in the next dividend bit, subtract the divisor if it fits.
module divider_integer_step #(
  parameter int unsigned WORD_WIDTH = 16
) (
  input  logic [WORD_WIDTH-1:0] partial_in,
  input  logic [WORD_WIDTH-1:0] divisor,
  input  logic                  dividend_bit,
  output logic [WORD_WIDTH-1:0] partial_out,
  output logic                  quotient_bit
);
  logic [WORD_WIDTH:0]   shifted;
  logic [WORD_WIDTH-1:0] diff;

  always_comb begin
    shifted      = {partial_in, dividend_bit};
    // A fitting subtraction always leaves a value below the divisor, so W bits suffice.
    diff         = shifted[WORD_WIDTH-1:0] - divisor;
    quotient_bit = (shifted >= {1'b0, divisor});
    partial_out  = quotient_bit ? diff : shifted[WORD_WIDTH-1:0];
  end

endmodule

// File: rtl/divider_integer_multimode.sv
// Iterative signed/unsigned restoring divider, BITS_PER_CYCLE quotient bits per cycle, tag pass-through.
// Optional feature: define DIVIDER_INTEGER_EARLY_OUT_EN to finish zero-divisor/overflow/zero-dividend ops in 1 cycle.
module divider_integer_multimode
  import divider_integer_pkg::*;
#(
  parameter int unsigned WORD_WIDTH     = 16,
  parameter int unsigned BITS_PER_CYCLE = 1,
  parameter int unsigned TAG_WIDTH      = 4
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  input_valid,
  output logic                  input_ready,
  input  logic [WORD_WIDTH-1:0] dividend,
  input  logic [WORD_WIDTH-1:0] divisor,
  input  logic                  signed_mode,
  input  logic [TAG_WIDTH-1:0]  input_tag,
  output logic                  output_valid,
  input  logic                  output_ready,
  output logic [WORD_WIDTH-1:0] quotient,
  output logic [WORD_WIDTH-1:0] remainder,
  output logic                  divide_by_zero,
  output logic                  overflow,
  output logic [TAG_WIDTH-1:0]  output_tag
);
  localparam int unsigned N  = num_iters(WORD_WIDTH, BITS_PER_CYCLE);
  localparam int unsigned CW = cnt_width(N);
  localparam logic [WORD_WIDTH-1:0] MIN_VAL = {1'b1, {(WORD_WIDTH-1){1'b0}}};

  if (!config_ok(WORD_WIDTH, BITS_PER_CYCLE, TAG_WIDTH)) begin : g_bad_config
    $error("divider_integer_multimode: WORD_WIDTH must be >= 2 and a multiple of BITS_PER_CYCLE");
  end

  state_t                                   state, state_next;
  logic [CW-1:0]                            cnt;
  logic [WORD_WIDTH-1:0]                    rem_r, quo_r, div_r, quo_next, res_q, res_r;
  logic [BITS_PER_CYCLE:0][WORD_WIDTH-1:0]  rem_chain;
  logic [BITS_PER_CYCLE-1:0]                q_bits;
  logic [TAG_WIDTH-1:0]                     tag_r;
  logic                                     neg_q_r, neg_r_r, dbz_r, ovf_r;
  logic                                     accept, last_iter, a_neg, b_neg, in_dbz, in_ovf;
  logic [WORD_WIDTH-1:0]                    a_mag, b_mag;
`ifdef DIVIDER_INTEGER_EARLY_OUT_EN
  logic                                     early_r;
`endif

  assign input_ready  = (state == IDLE) && !clear;
  assign output_valid = (state == DONE);
  assign accept       = (state == IDLE) && input_valid;

  always_comb begin
    a_neg  = signed_mode & dividend[WORD_WIDTH-1];
    b_neg  = signed_mode & divisor[WORD_WIDTH-1];
    a_mag  = a_neg ? -dividend : dividend;
    b_mag  = b_neg ? -divisor : divisor;
    in_dbz = (divisor == '0);
    in_ovf = signed_mode && (dividend == MIN_VAL) && (divisor == '1);
  end

  // Partial remainder chain; quo_r holds unconsumed dividend bits (MSB first) and
  // fills with quotient bits from the bottom as they are retired.
  assign rem_chain[0] = rem_r;
  for (genvar k = 0; k < BITS_PER_CYCLE; k++) begin : g_step
    divider_integer_step #(.WORD_WIDTH(WORD_WIDTH)) u_step (
      .partial_in  (rem_chain[k]),
      .divisor     (div_r),
      .dividend_bit(quo_r[WORD_WIDTH-1-k]),
      .partial_out (rem_chain[k+1]),
      .quotient_bit(q_bits[BITS_PER_CYCLE-1-k])
    );
  end

  if (BITS_PER_CYCLE == WORD_WIDTH) begin : g_quo_full
    assign quo_next = q_bits;
  end else begin : g_quo_shift
    assign quo_next = {quo_r[WORD_WIDTH-BITS_PER_CYCLE-1:0], q_bits};
  end

  // A zero divisor retires all-ones magnitude bits and leaves |dividend| as remainder,
  // so only the quotient needs overriding; MIN/-1 falls out of the magnitudes naturally.
  always_comb begin
    res_q     = dbz_r ? '1 : (neg_q_r ? -quo_next : quo_next);
    res_r     = neg_r_r ? -rem_chain[BITS_PER_CYCLE] : rem_chain[BITS_PER_CYCLE];
    last_iter = (cnt == CW'(1));
`ifdef DIVIDER_INTEGER_EARLY_OUT_EN
    if (early_r) begin
      last_iter = 1'b1;
      res_q     = dbz_r ? '1 : (ovf_r ? MIN_VAL : '0);
      res_r     = dbz_r ? (neg_r_r ? -quo_r : quo_r) : '0;
    end
`endif
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (input_valid)  state_next = CALC;
      CALC:    if (last_iter)    state_next = DONE;
      DONE:    if (output_ready) state_next = IDLE;
      default:                   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      cnt            <= '0;
      rem_r          <= '0;
      quo_r          <= '0;
      div_r          <= '0;
      neg_q_r        <= 1'b0;
      neg_r_r        <= 1'b0;
      dbz_r          <= 1'b0;
      ovf_r          <= 1'b0;
      tag_r          <= '0;
      quotient       <= '0;
      remainder      <= '0;
      divide_by_zero <= 1'b0;
      overflow       <= 1'b0;
      output_tag     <= '0;
`ifdef DIVIDER_INTEGER_EARLY_OUT_EN
      early_r        <= 1'b0;
`endif
    end else if (accept) begin
      cnt     <= CW'(N);
      rem_r   <= '0;
      quo_r   <= a_mag;
      div_r   <= b_mag;
      neg_q_r <= a_neg ^ b_neg;
      neg_r_r <= a_neg;
      dbz_r   <= in_dbz;
      ovf_r   <= in_ovf;
      tag_r   <= input_tag;
`ifdef DIVIDER_INTEGER_EARLY_OUT_EN
      early_r <= in_dbz | in_ovf | (dividend == '0);
`endif
    end else if (state == CALC) begin
      cnt   <= cnt - 1'b1;
      rem_r <= rem_chain[BITS_PER_CYCLE];
      quo_r <= quo_next;
      if (last_iter) begin
        quotient       <= res_q;
        remainder      <= res_r;
        divide_by_zero <= dbz_r;
        overflow       <= ovf_r;
        output_tag     <= tag_r;
      end
    end
  end

endmodule

// File: tb/tb_divider_integer_multimode.sv
// Bench for divider_integer_multimode: W=8 at BPC=1 and BPC=2, checked against an arithmetic model.
module tb_divider_integer_multimode;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
    logic       of;
    logic [3:0] tag;
    int         lat;
    int         acc;
  } exp_t;

  logic       clk = 1'b0;
  logic       clear;
  logic       iv [2];
  logic       ir [2];
  logic       ov [2];
  logic       ordy [2];
  logic       sm [2];
  logic       dz [2];
  logic       of [2];
  logic [7:0] dvd [2];
  logic [7:0] dvs [2];
  logic [7:0] qo [2];
  logic [7:0] ro [2];
  logic [3:0] ti [2];
  logic [3:0] tg [2];

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  exp_t pend [2];
  bit   busy [2];
  bit   seen [2];
  bit   have_prev [2];
  int   prev_acc [2];
  int   prev_lat [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  divider_integer_multimode #(.WORD_WIDTH(8), .BITS_PER_CYCLE(1), .TAG_WIDTH(4)) dut0 (
    .clock(clk), .clear(clear), .input_valid(iv[0]), .input_ready(ir[0]),
    .dividend(dvd[0]), .divisor(dvs[0]), .signed_mode(sm[0]), .input_tag(ti[0]),
    .output_valid(ov[0]), .output_ready(ordy[0]), .quotient(qo[0]), .remainder(ro[0]),
    .divide_by_zero(dz[0]), .overflow(of[0]), .output_tag(tg[0])
  );

  divider_integer_multimode #(.WORD_WIDTH(8), .BITS_PER_CYCLE(2), .TAG_WIDTH(4)) dut1 (
    .clock(clk), .clear(clear), .input_valid(iv[1]), .input_ready(ir[1]),
    .dividend(dvd[1]), .divisor(dvs[1]), .signed_mode(sm[1]), .input_tag(ti[1]),
    .output_valid(ov[1]), .output_ready(ordy[1]), .quotient(qo[1]), .remainder(ro[1]),
    .divide_by_zero(dz[1]), .overflow(of[1]), .output_tag(tg[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer division (truncating) plus the special cases.
  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                 input logic s, input logic [3:0] t);
    exp_t e;
    int   sa, sb;
    e.tag = t; e.dz = 1'b0; e.of = 1'b0; e.lat = 0; e.acc = 0;
    sa = s ? int'($signed(a)) : int'(a);
    sb = s ? int'($signed(b)) : int'(b);
    if (b == 8'd0) begin
      e.q = 8'hFF; e.r = a; e.dz = 1'b1;
    end else if (s && sa == -128 && sb == -1) begin
      e.q = 8'h80; e.r = 8'h00; e.of = 1'b1;
    end else begin
      e.q = 8'(sa / sb);
      e.r = 8'(sa % sb);
    end
    return e;
  endfunction

  function automatic int exp_lat(input int k, input logic [7:0] a, input logic [7:0] b,
                                 input logic s);
`ifdef DIVIDER_INTEGER_EARLY_OUT_EN
    if (b == 8'd0 || a == 8'd0 || (s && a == 8'h80 && b == 8'hFF)) return 1;
`endif
    return (k == 0) ? 8 : 4;
  endfunction

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (clear) begin
        chk("clear_valid", ov[k], 0);
        chk("clear_ready", ir[k], 0);
        chk("clear_quotient", qo[k], 0);
        chk("clear_remainder", ro[k], 0);
        chk("clear_dbz", dz[k], 0);
        chk("clear_ovf", of[k], 0);
        chk("clear_tag", tg[k], 0);
        busy[k] = 0; seen[k] = 0; have_prev[k] = 0;
      end else begin
        if (ov[k]) begin
          if (!busy[k]) chk("spurious_valid", ov[k], 0);
          else begin
            chk("quotient", qo[k], pend[k].q);
            chk("remainder", ro[k], pend[k].r);
            chk("divide_by_zero", dz[k], pend[k].dz);
            chk("overflow", of[k], pend[k].of);
            chk("output_tag", tg[k], pend[k].tag);
            chk("ready_in_done", ir[k], 0);
            if (!seen[k]) begin
              chk("latency", cyc - pend[k].acc, pend[k].lat);
              seen[k] = 1;
            end
            if (ordy[k]) begin busy[k] = 0; seen[k] = 0; end
          end
        end else if (busy[k]) begin
          chk("ready_while_busy", ir[k], 0);
        end
        if (iv[k] && ir[k]) begin
          int acc;
          acc = cyc + 1;
          if (have_prev[k]) chk("issue_interval_ok", (acc - prev_acc[k]) >= (prev_lat[k] + 2), 1);
          pend[k]      = model(dvd[k], dvs[k], sm[k], ti[k]);
          pend[k].acc  = acc;
          pend[k].lat  = exp_lat(k, dvd[k], dvs[k], sm[k]);
          busy[k]      = 1;
          have_prev[k] = 1;
          prev_acc[k]  = acc;
          prev_lat[k]  = pend[k].lat;
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge plus a short
  // input_valid pulse that must be ignored while the engine is busy.
  task automatic start_op(input int k, input logic [7:0] a, input logic [7:0] b,
                          input logic s, input logic [3:0] t);
    int g;
    iv[k] = 1'b1; dvd[k] = a; dvs[k] = b; sm[k] = s; ti[k] = t;
    g = 0;
    @(negedge clk);
    while (!ir[k] && g < 50) begin @(negedge clk); g++; end
    if (g >= 50) chk("accept_timeout", ir[k], 1);
    @(posedge clk); #1;
    iv[k] = 1'b0; dvd[k] = 8'($urandom); dvs[k] = 8'($urandom);
    sm[k] = 1'($urandom); ti[k] = 4'($urandom);
    @(posedge clk); #1 iv[k] = 1'b1;
    @(posedge clk); #1 iv[k] = 1'b0;
  endtask

  task automatic finish_op(input int k, input int hold, output logic [7:0] q,
                           output logic [7:0] r, output logic d, output logic o,
                           output logic [3:0] t);
    int g;
    g = 0;
    @(negedge clk);
    while (!ov[k] && g < 200) begin @(negedge clk); g++; end
    if (g >= 200) chk("result_timeout", ov[k], 1);
    q = qo[k]; r = ro[k]; d = dz[k]; o = of[k]; t = tg[k];
    repeat (hold) @(posedge clk);
    @(posedge clk); #1 ordy[k] = 1'b1;
    @(posedge clk); #1 ordy[k] = 1'b0;
  endtask

  task automatic directed(input string nm, input logic [7:0] a, input logic [7:0] b,
                          input logic s, input logic [3:0] t, input logic [7:0] eq,
                          input logic [7:0] er, input logic ed, input logic eo);
    logic [7:0] q, r;
    logic       d, o;
    logic [3:0] tt;
    start_op(0, a, b, s, t);
    finish_op(0, 0, q, r, d, o, tt);
    chk({nm, "_q"}, q, eq);
    chk({nm, "_r"}, r, er);
    chk({nm, "_dbz"}, d, ed);
    chk({nm, "_ovf"}, o, eo);
    chk({nm, "_tag"}, tt, t);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t       m;
    logic [7:0] q, r, a, b;
    logic       d, o, s;
    logic [3:0] tt;
    clear = 1'b1;
    for (int k = 0; k < 2; k++) begin
      iv[k] = 0; ordy[k] = 0; sm[k] = 0; dvd[k] = '0; dvs[k] = '0; ti[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1 clear = 1'b0;
    @(negedge clk);
    chk("ready_after_reset0", ir[0], 1);
    chk("ready_after_reset1", ir[1], 1);
    @(posedge clk); #1;

    m = model(8'd200, 8'd7, 1'b0, 4'h0);
    chk("model_200_7_q", m.q, 28);
    chk("model_200_7_r", m.r, 4);
    m = model(8'hF9, 8'h02, 1'b1, 4'h0);
    chk("model_m7_2_q", m.q, 8'hFD);
    chk("model_m7_2_r", m.r, 8'hFF);
    m = model(8'h07, 8'hFE, 1'b1, 4'h0);
    chk("model_7_m2_r", m.r, 8'h01);

    directed("u200_7",    8'd200, 8'd7,  1'b0, 4'hA, 8'd28,  8'd4,  1'b0, 1'b0);
    directed("s_m7_2",    8'hF9,  8'h02, 1'b1, 4'h3, 8'hFD,  8'hFF, 1'b0, 1'b0);
    directed("s_7_m2",    8'h07,  8'hFE, 1'b1, 4'h5, 8'hFD,  8'h01, 1'b0, 1'b0);
    directed("u_f9_2",    8'hF9,  8'h02, 1'b0, 4'h6, 8'h7C,  8'h01, 1'b0, 1'b0);
    directed("dbz_5_0",   8'd5,   8'd0,  1'b0, 4'h7, 8'hFF,  8'h05, 1'b1, 1'b0);
    directed("s_dbz_m3",  8'hFD,  8'd0,  1'b1, 4'h8, 8'hFF,  8'hFD, 1'b1, 1'b0);
    directed("s_min_m1",  8'h80,  8'hFF, 1'b1, 4'h9, 8'h80,  8'h00, 1'b0, 1'b1);
    directed("u_80_ff",   8'h80,  8'hFF, 1'b0, 4'hB, 8'h00,  8'h80, 1'b0, 1'b0);
    directed("zero_div",  8'd0,   8'd9,  1'b1, 4'hC, 8'h00,  8'h00, 1'b0, 1'b0);

    // Clear while a result is held in DONE: outputs drop without a clock edge.
    start_op(0, 8'd77, 8'd5, 1'b0, 4'hD);
    for (int g = 0; g < 200 && !ov[0]; g++) @(negedge clk);
    chk("done_before_clear", ov[0], 1);
    @(posedge clk); #1 clear = 1'b1;
    #1;
    chk("clear_async_valid", ov[0], 0);
    chk("clear_async_q", qo[0], 0);
    @(posedge clk); #1 clear = 1'b0;
    @(negedge clk);
    chk("ready_after_clear_done", ir[0], 1);
    @(posedge clk); #1;

    // Clear in the middle of CALC; the discarded op must never surface.
    start_op(0, 8'd250, 8'd3, 1'b0, 4'hE);
    @(posedge clk); #1 clear = 1'b1;
    #1;
    chk("clear_calc_valid", ov[0], 0);
    @(posedge clk); #1 clear = 1'b0;
    @(negedge clk);
    chk("ready_after_clear_calc", ir[0], 1);
    @(posedge clk); #1;
    directed("post_clear", 8'd100, 8'd10, 1'b0, 4'h1, 8'd10, 8'd0, 1'b0, 1'b0);

    for (int i = 0; i < 12; i++) begin
      a = 8'($urandom); b = 8'($urandom_range(0, 20)); s = 1'($urandom);
      start_op(0, a, b, s, 4'($urandom));
      finish_op(0, $urandom_range(0, 3), q, r, d, o, tt);
    end

    for (int i = 0; i < 30; i++) begin
      a = 8'($urandom); b = 8'($urandom); s = 1'($urandom);
      case ($urandom_range(0, 9))
        0: b = 8'd0;
        1: begin a = 8'h80; b = 8'hFF; end
        2: a = 8'd0;
        3: b = 8'($urandom_range(1, 4));
        default: ;
      endcase
      start_op(1, a, b, s, 4'($urandom));
      finish_op(1, 5, q, r, d, o, tt);
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
